sdf_bf2_stage4: RTL
===================

Name: sdf_bf2_stage4

Overview:
- Radix-2 single-path delay-feedback (R2SDF) butterfly element for stage 4 (delay D=2) of the 32-point DIF FFT.
- Consumes the 22-bit complex stream leaving the stage-3 element and emits the stage-4 stream to the stage-5 (D=1) element.
- Embeds its own 2-entry feedback delay, add/subtract butterfly, trivial W4 twiddle (1 or -j), output valid generation and end-of-stream flush with back-pressure.

Parameters:
- DW, 22, real/imag sample width, two's complement.
- N, 32, samples per frame.
- D, 2, feedback delay depth (fixed for stage 4).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input sample present
- in_ready  out  1  block accepts a sample this cycle
- data_real_in  in  DW  input real
- data_imag_in  in  DW  input imag
- out_valid  out  1  output sample valid
- data_real_out  out  DW  output real, registered
- data_imag_out  out  DW  output imag, registered

Behaviour:
- Reset: cnt=0, have_diff=0, state IDLE, delay entries 0. Outputs: out_valid=0, data_*_out=0, in_ready=1.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE: waits for in_valid, then goes to RUN.
  - RUN: described by the step rules below.
  - FLUSH: one cycle, then IDLE.
- in_ready is 0 only in FLUSH.
- step = (in_valid && in_ready) || flush_step. Only a step advances cnt (5-bit, mod 32), the delay line and the output register.
- In-frame gaps (in_valid=0, no flush condition) hold all state; out_valid=0 in those cycles.
- Phase = cnt[1]. d = delay head, i.e. the sample x[n-2] or the stored difference.
- Phase 0 (cnt[1:0]=00/01):
  - Input pushed into the delay line.
  - Output = d, unchanged when cnt[0]=0; multiplied by -j when cnt[0]=1, i.e. (re,im) -> (im,-re).
  - out_valid = have_diff.
- Phase 1 (cnt[1:0]=10/11):
  - Output = sat(d + x), out_valid=1.
  - Delay line receives sat(d - x).
- have_diff: set on a step at cnt[1:0]=11; cleared on a step at cnt[1:0]=01.
- Flush:
  - Trigger: state RUN, cnt=0, have_diff=1, in_valid=0.
  - That cycle does a flush step with x=0 and emits diff0, cnt->1, state->FLUSH.
  - FLUSH does a second flush step emitting -j*diff1, then forces cnt=0, have_diff=0, state->IDLE.
- Back-to-back frames: sample 0 of the next frame arriving at cnt=0 is a normal step. The previous frame's diffs emerge in phase 0 with no bubble.
- Output order per block b: X4b+X4b+2, X4b+1+X4b+3, X4b-X4b+2, -j(X4b+1-X4b+3). There are 32 valid outputs per frame.
- Latency: output registered 1 cycle after its step.
- Arithmetic: add/sub at DW+1 bits, saturate to [-2^21, 2^21-1]. -j negation of -2^21 saturates to 2^21-1. No rounding or scaling.
- Reset mid-operation: returns to reset state immediately; the partial frame and any pending diffs are discarded.

Decomposition:
- Shared package fft_pkg:
  - DW, N constants.
  - cplx_t struct (re, im).
  - sat_add/sat_sub/neg_sat functions.
  - Stage-delay constants D16..D1 for the sibling stages.
- Sub-module sdf_bf2_core: combinational butterfly plus twiddle select (inputs d, x, phase, cnt[0]). Reused by stages 1-3 with a twiddle ROM in place of the -j select.

Test Plan:
- Reset check: assert rst_n=0 -> out_valid=0, data_*_out=0, in_ready=1. Release with idle input -> no change.
- Single frame, real ramp x[n]=n, imag 0, contiguous:
  - Outputs 2, 4, -2, (0,+2j), 10, 12, -2, (0,+2j), ...
  - FLUSH cycle shows in_ready=0; exactly 32 out_valid pulses; the last two are the block-7 diffs.
- Two frames back-to-back (second frame constant 1+1j): frame-1 diffs interleave in phase 0 with no gap. Frame-2 outputs: sums (2,2j), diffs 0. in_ready stays 1 at the frame boundary.
- Mid-frame gap: drop in_valid for 3 cycles at cnt=5 -> state held, out_valid=0 during gap. Output sequence identical to the contiguous ramp.
- Saturation: x = 2^21-1 at cnt=0 and cnt=2 -> sum saturates to 2^21-1. x=-2^21 real at cnt=1, 0 at cnt=3 -> -j diff im = 2^21-1.
- Reset asserted at cnt=13 -> outputs zero next edge. A fresh ramp frame afterwards reproduces the single-frame results exactly.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types, constants and saturating arithmetic for the 32-point R2SDF FFT pipeline.
package fft_pkg;

  localparam int unsigned DW   = 22;
  localparam int unsigned N    = 32;
  localparam int unsigned CntW = $clog2(N);

  // Feedback delay depth of each R2SDF stage, stage 1 first.
  localparam int unsigned D16 = 16;
  localparam int unsigned D8  = 8;
  localparam int unsigned D4  = 4;
  localparam int unsigned D2  = 2;
  localparam int unsigned D1  = 1;

  typedef logic signed [DW-1:0] sample_t;

  localparam sample_t SatMax = {1'b0, {(DW-1){1'b1}}};
  localparam sample_t SatMin = {1'b1, {(DW-1){1'b0}}};

  typedef struct packed {
    sample_t re;
    sample_t im;
  } cplx_t;

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_t;

  // Clamp a DW+1 bit result back into DW bits.
  function automatic sample_t sat_ext(input logic signed [DW:0] s);
    if (s[DW] != s[DW-1]) return s[DW] ? SatMin : SatMax;
    return s[DW-1:0];
  endfunction

  function automatic sample_t sat_add(input sample_t a, input sample_t b);
    return sat_ext({a[DW-1], a} + {b[DW-1], b});
  endfunction

  function automatic sample_t sat_sub(input sample_t a, input sample_t b);
    return sat_ext({a[DW-1], a} - {b[DW-1], b});
  endfunction

  function automatic sample_t neg_sat(input sample_t a);
    return (a == SatMin) ? SatMax : -a;
  endfunction

endpackage

// File: rtl/sdf_bf2_core.sv
// Combinational R2SDF butterfly with the trivial W4 twiddle (1 or -j) on the delay-head path.
module sdf_bf2_core import fft_pkg::*; (
  input  cplx_t d,
  input  cplx_t x,
  input  logic  phase,
  input  logic  odd,
  output cplx_t y,
  output cplx_t fb
);

  always_comb begin
    y  = d;
    fb = x;
    if (phase) begin
      y.re  = sat_add(d.re, x.re);
      y.im  = sat_add(d.im, x.im);
      fb.re = sat_sub(d.re, x.re);
      fb.im = sat_sub(d.im, x.im);
    end else if (odd) begin
      // Multiply by -j: (re, im) -> (im, -re).
      y.re = d.im;
      y.im = neg_sat(d.re);
    end
  end

endmodule

// File: rtl/sdf_bf2_stage4.sv
// Stage-4 (D=2) R2SDF element: delay feedback, butterfly, -j twiddle and end-of-frame flush.
module sdf_bf2_stage4 import fft_pkg::*; (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] data_real_in,
  input  logic [DW-1:0] data_imag_in,
  output logic          out_valid,
  output logic [DW-1:0] data_real_out,
  output logic [DW-1:0] data_imag_out
);

  localparam int unsigned D = D2;

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            have_diff_q, have_diff_d;
  cplx_t           dl_q [D];
  cplx_t           x, y, fb, out_q;
  logic            out_valid_q;
  logic            flush_trig, flush_step, step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRun;
      StRun:   if (flush_trig) state_d = StFlush;
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A finished frame with pending diffs and no next sample drains them as two x=0 steps.
  always_comb begin
    in_ready   = (state_q != StFlush);
    flush_trig = (state_q == StRun) && (cnt_q == '0) && have_diff_q && !in_valid;
    flush_step = flush_trig || (state_q == StFlush);
    step       = (in_valid && in_ready) || flush_step;
  end

  always_comb begin
    x = '0;
    if (!flush_step) begin
      x.re = data_real_in;
      x.im = data_imag_in;
    end
  end

  sdf_bf2_core u_core (
    .d     (dl_q[D-1]),
    .x     (x),
    .phase (cnt_q[1]),
    .odd   (cnt_q[0]),
    .y     (y),
    .fb    (fb)
  );

  always_comb begin
    cnt_d       = cnt_q;
    have_diff_d = have_diff_q;
    if (step) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q[1:0] == 2'b11)      have_diff_d = 1'b1;
      else if (cnt_q[1:0] == 2'b01) have_diff_d = 1'b0;
    end
    if (state_q == StFlush) begin
      cnt_d       = '0;
      have_diff_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      have_diff_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      for (int i = 0; i < D; i++) dl_q[i] <= '0;
    end else begin
      cnt_q       <= cnt_d;
      have_diff_q <= have_diff_d;
      out_valid_q <= step && (cnt_q[1] || have_diff_q);
      if (step) begin
        out_q   <= y;
        dl_q[0] <= fb;
        for (int i = 1; i < D; i++) dl_q[i] <= dl_q[i-1];
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign data_real_out = out_q.re;
  assign data_imag_out = out_q.im;

endmodule
